// File: rtl/adc_serial_rx_multi_pkg.sv
// Shared constants and helpers for the multi-channel serial ADC receiver.
package adc_serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int shift_cycles(input int sclk_div, input int frame_bits);
    return 2 * sclk_div * frame_bits;
  endfunction

  // DATA_W >= 4 keeps the test-pattern frame counter at least one bit wide.
  function automatic bit cfg_legal(input int num_ch, input int frame_bits, input int data_w,
                                   input int lsb_pos, input int sclk_div, input int cs_setup,
                                   input int cycle_cnt);
    return (num_ch >= 1) && (num_ch <= 8) && (frame_bits >= 8) && (frame_bits <= 32) &&
           (data_w >= 4) && (lsb_pos >= 0) && (lsb_pos + data_w <= frame_bits) &&
           (sclk_div >= 1) && (cs_setup >= 1) && (cycle_cnt >= 1);
  endfunction

endpackage

// File: rtl/adc_serial_rx_multi_if.sv
// AXI-Stream style sample output bundle.
interface adc_serial_rx_multi_if #(parameter int TDATA_W = 24);
  logic [TDATA_W-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;

  modport master (output m_tdata, output m_tvalid, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, output m_tready);
endinterface

// File: rtl/adc_serial_rx_multi_sclk_gen.sv
// SCLK half-period divider and frame bit counter; sclk_o idles high.
module adc_sclk_gen #(
  parameter int FRAME_BITS = 16,
  parameter int SCLK_DIV   = 2
) (
  input  logic fpga_clk_i,
  input  logic reset_n_i,
  input  logic start_i,     // last SETUP cycle: arm the first low phase
  input  logic run_i,       // high for the whole SHIFT state
  output logic sclk_o,
  output logic sample_stb,  // last low-phase cycle of a bit
  output logic bit_end,     // last high-phase cycle of a bit
  output logic last_bit
);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          half_end;

  assign half_end   = run_i && (div_cnt == DW'(SCLK_DIV - 1));
  assign sample_stb = half_end && !sclk_o;
  assign bit_end    = half_end && sclk_o;
  assign last_bit   = (bit_cnt == '0);

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sclk_o  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (start_i) begin
      sclk_o  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= BW'(FRAME_BITS - 1);
    end else if (half_end) begin
      div_cnt <= '0;
      if (!sclk_o) begin
        sclk_o <= 1'b1;
      end else if (!last_bit) begin
        sclk_o  <= 1'b0;
        bit_cnt <= bit_cnt - 1'b1;
      end
    end else if (run_i) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/adc_serial_rx_multi.sv
// N-channel simultaneous serial ADC receiver with AXIS-style output and overrun flag.
// Optional build macro ADC_TEST_PATTERN_EN adds test_mode_i and a per-frame pattern source.
module adc_serial_rx_multi
  import adc_serial_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12,
  parameter int LSB_POS    = 2,
  parameter int SCLK_DIV   = 2,
  parameter int CS_SETUP   = 2,
  parameter int CYCLE_CNT  = 200
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic [NUM_CH-1:0]     en_i,
  input  logic [NUM_CH-1:0]     sdata_i,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                  test_mode_i,
`endif
  output logic                  sclk_o,
  output logic                  cs_o,
  adc_serial_rx_multi_if.master m_axis,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i,
  output logic                  busy_o
);
  localparam int PW = $clog2(CYCLE_CNT + 1);
  localparam int SW = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
  // Only the low LSB_POS+DATA_W frame bits matter; older bits fall off the top.
  localparam int RW = LSB_POS + DATA_W;

  generate
    if (!cfg_legal(NUM_CH, FRAME_BITS, DATA_W, LSB_POS, SCLK_DIV, CS_SETUP, CYCLE_CNT)) begin : g_bad_cfg
      $error("adc_serial_rx_multi: illegal parameter combination");
    end
  endgenerate

  logic [1:0]                    state, state_nxt;
  logic [PW-1:0]                 period_cnt;
  logic [SW-1:0]                 setup_cnt;
  logic [NUM_CH-1:0]             en_q;
  logic [NUM_CH-1:0][RW-1:0]     sreg;
  logic [NUM_CH-1:0][DATA_W-1:0] field;
  logic frame_go, start, sample_stb, bit_end, last_bit, accept, drop;

  assign frame_go = (state == ST_IDLE) && (period_cnt == '0) && (|en_i);
  assign start    = (state == ST_SETUP) && (setup_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_go) state_nxt = ST_SETUP;
      ST_SETUP: if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_end && last_bit) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  adc_sclk_gen #(.FRAME_BITS(FRAME_BITS), .SCLK_DIV(SCLK_DIV)) u_sclk (
    .fpga_clk_i (fpga_clk_i),
    .reset_n_i  (reset_n_i),
    .start_i    (start),
    .run_i      (state == ST_SHIFT),
    .sclk_o     (sclk_o),
    .sample_stb (sample_stb),
    .bit_end    (bit_end),
    .last_bit   (last_bit)
  );

  // cs_o/busy_o follow next state so both pins are registered yet line up with the FSM.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= ST_IDLE;
      period_cnt <= '0;
      setup_cnt  <= '0;
      en_q       <= '0;
      cs_o       <= 1'b1;
      busy_o     <= 1'b0;
    end else begin
      state  <= state_nxt;
      cs_o   <= !((state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT));
      busy_o <= (state_nxt != ST_IDLE);
      if (frame_go) begin
        period_cnt <= PW'(CYCLE_CNT - 1);
        setup_cnt  <= SW'(CS_SETUP - 1);
        en_q       <= en_i;
      end else begin
        if (period_cnt != '0) period_cnt <= period_cnt - 1'b1;
        if ((state == ST_SETUP) && (setup_cnt != '0)) setup_cnt <= setup_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sreg <= '0;
    end else if (sample_stb) begin
      for (int k = 0; k < NUM_CH; k++) sreg[k] <= {sreg[k][RW-2:0], sdata_i[k]};
    end
  end

`ifdef ADC_TEST_PATTERN_EN
  logic [DATA_W-4:0] frame_cnt;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i)            frame_cnt <= '0;
    else if (state == ST_DONE) frame_cnt <= frame_cnt + 1'b1;
  end

  always_comb begin
    field = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (en_q[k]) field[k] = test_mode_i ? {frame_cnt, 3'(k)} : sreg[k][RW-1:LSB_POS];
    end
  end
`else
  always_comb begin
    field = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (en_q[k]) field[k] = sreg[k][RW-1:LSB_POS];
    end
  end
`endif

  assign accept = (state == ST_DONE) && (!m_axis.m_tvalid || m_axis.m_tready);
  assign drop   = (state == ST_DONE) && m_axis.m_tvalid && !m_axis.m_tready;

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_axis.m_tdata  <= '0;
      m_axis.m_tvalid <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      if (accept) begin
        m_axis.m_tdata  <= field;
        m_axis.m_tvalid <= 1'b1;
      end else if (m_axis.m_tvalid && m_axis.m_tready) begin
        m_axis.m_tvalid <= 1'b0;
      end
      if (drop)               overrun_o <= 1'b1;
      else if (overrun_clr_i) overrun_o <= 1'b0;
    end
  end
endmodule
